// File: rtl/controller_reduce_seq.sv
// ============================================================================
// controller_reduce_seq : operator-precedence reduction sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module controller_reduce_seq #(
    parameter int OP_W   = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_op_valid,
    input  logic [OP_W-1:0]   i_op_in,
    output logic              o_ready,
    input  logic              i_clr,
    input  logic [OP_W-1:0]   i_op_data,
    input  logic              i_op_empty,
    output logic              o_op_push,
    output logic [OP_W-1:0]   o_op_wdata,
    output logic              o_op_pop,
    input  logic [DATA_W-1:0] i_dt_data,
    input  logic              i_dt_empty,
    output logic              o_dt_push,
    output logic [DATA_W-1:0] o_dt_wdata,
    output logic              o_dt_pop,
    output logic [DATA_W-1:0] o_al_a,
    output logic [DATA_W-1:0] o_al_b,
    output logic [OP_W-1:0]   o_al_op,
    output logic              o_al_start,
    input  logic              i_al_done,
    input  logic [DATA_W-1:0] i_al_c,
    input  logic              i_al_err,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result,
    output logic              o_error
);

    localparam logic [OP_W-1:0] c_OP_NO = OP_W'(0);
    localparam logic [OP_W-1:0] c_OP_AD = OP_W'(1);
    localparam logic [OP_W-1:0] c_OP_SB = OP_W'(2);
    localparam logic [OP_W-1:0] c_OP_MU = OP_W'(3);
    localparam logic [OP_W-1:0] c_OP_DI = OP_W'(4);
    localparam logic [OP_W-1:0] c_OP_LP = OP_W'(5);
    localparam logic [OP_W-1:0] c_OP_RP = OP_W'(6);
    localparam logic [OP_W-1:0] c_OP_OK = OP_W'(7);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CHECK  = 4'd1,
        S_POPB   = 4'd2,
        S_POPA   = 4'd3,
        S_EXEC   = 4'd4,
        S_WAIT   = 4'd5,
        S_PUSHR  = 4'd6,
        S_PUSHOP = 4'd7,
        S_FINAL  = 4'd8,
        S_ERR    = 4'd9
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [OP_W-1:0]     r_cur;
    logic [OP_W-1:0]     r_aop;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_r;
    logic [DATA_W-1:0]   r_result;
    logic                w_ld_cur;
    logic                w_ld_b;
    logic                w_ld_a;
    logic                w_ld_r;
    logic                w_ld_res;

    function automatic logic f_is_bin(input logic [OP_W-1:0] op);
        return (op == c_OP_AD) || (op == c_OP_SB) || (op == c_OP_MU) || (op == c_OP_DI);
    endfunction

    function automatic logic [1:0] f_prec(input logic [OP_W-1:0] op);
        if ((op == c_OP_MU) || (op == c_OP_DI))
            return 2'd2;
        else if ((op == c_OP_AD) || (op == c_OP_SB))
            return 2'd1;
        else
            return 2'd0;
    endfunction

    always_comb begin
        w_next     = r_state;
        o_ready    = 1'b0;
        o_op_push  = 1'b0;
        o_op_pop   = 1'b0;
        o_dt_push  = 1'b0;
        o_dt_pop   = 1'b0;
        o_al_start = 1'b0;
        o_done     = 1'b0;
        w_ld_cur   = 1'b0;
        w_ld_b     = 1'b0;
        w_ld_a     = 1'b0;
        w_ld_r     = 1'b0;
        w_ld_res   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_op_valid && (i_op_in != c_OP_NO)) begin
                    w_ld_cur = 1'b1;
                    w_next   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_cur == c_OP_LP) begin
                    w_next = S_PUSHOP;
                end else if (i_op_empty) begin
                    if (r_cur == c_OP_RP)      w_next = S_ERR;
                    else if (r_cur == c_OP_OK) w_next = S_FINAL;
                    else                       w_next = S_PUSHOP;
                end else if (i_op_data == c_OP_LP) begin
                    if (r_cur == c_OP_RP) begin
                        o_op_pop = 1'b1;
                        w_next   = S_IDLE;
                    end else if (r_cur == c_OP_OK) begin
                        w_next = S_ERR;
                    end else begin
                        w_next = S_PUSHOP;
                    end
                end else if (f_is_bin(i_op_data)) begin
                    // Equal precedence reduces first, giving left associativity.
                    if (f_is_bin(r_cur) && (f_prec(r_cur) > f_prec(i_op_data)))
                        w_next = S_PUSHOP;
                    else
                        w_next = S_POPB;
                end else begin
                    w_next = S_ERR;
                end
            end
            S_POPB: begin
                if (i_dt_empty) begin
                    w_next = S_ERR;
                end else begin
                    w_ld_b   = 1'b1;
                    o_dt_pop = 1'b1;
                    w_next   = S_POPA;
                end
            end
            S_POPA: begin
                if (i_dt_empty) begin
                    w_next = S_ERR;
                end else begin
                    w_ld_a   = 1'b1;
                    o_dt_pop = 1'b1;
                    o_op_pop = 1'b1;
                    w_next   = S_EXEC;
                end
            end
            S_EXEC: begin
                o_al_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (i_al_done) begin
                    if (i_al_err) begin
                        w_next = S_ERR;
                    end else begin
                        w_ld_r = 1'b1;
                        w_next = S_PUSHR;
                    end
                end
            end
            S_PUSHR: begin
                o_dt_push = 1'b1;
                w_next    = S_CHECK;
            end
            S_PUSHOP: begin
                o_op_push = 1'b1;
                w_next    = S_IDLE;
            end
            S_FINAL: begin
                if (i_dt_empty) begin
                    w_next = S_ERR;
                end else begin
                    w_ld_res = 1'b1;
                    o_dt_pop = 1'b1;
                    o_done   = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            S_ERR: begin
                if (i_clr) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_aop    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_r      <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_ld_cur) r_cur <= i_op_in;
            if (w_ld_b)   r_b   <= i_dt_data;
            if (w_ld_a) begin
                r_a   <= i_dt_data;
                r_aop <= i_op_data;
            end
            if (w_ld_r)   r_r      <= i_al_c;
            if (w_ld_res) r_result <= i_dt_data;
        end
    end

    // Error is sticky simply because ERR is only left through clr or reset.
    assign o_error    = (r_state == S_ERR);
    assign o_op_wdata = r_cur;
    assign o_dt_wdata = r_r;
    assign o_al_a     = r_a;
    assign o_al_b     = r_b;
    assign o_al_op    = r_aop;
    assign o_result   = r_result;

endmodule

`default_nettype wire

// File: tb/tb_controller_reduce_seq.sv
// ============================================================================
// tb_controller_reduce_seq : directed bench with stack and ALU models
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_controller_reduce_seq;

    localparam logic [2:0] NO = 3'd0, AD = 3'd1, SB = 3'd2, MU = 3'd3,
                           DI = 3'd4, LP = 3'd5, RP = 3'd6, OK = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_in = 3'd0;
    logic        ready;
    logic        clr = 1'b0;
    logic [2:0]  op_data;
    logic        op_empty;
    logic        op_push;
    logic [2:0]  op_wdata;
    logic        op_pop;
    logic [31:0] dt_data;
    logic        dt_empty;
    logic        dt_push;
    logic [31:0] dt_wdata;
    logic        dt_pop;
    logic [31:0] al_a;
    logic [31:0] al_b;
    logic [2:0]  al_op;
    logic        al_start;
    logic        al_done = 1'b0;
    logic [31:0] al_c = 32'd0;
    logic        al_err = 1'b0;
    logic        done;
    logic [31:0] result;
    logic        error;

    controller_reduce_seq #(.OP_W(3), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_op_valid(op_valid), .i_op_in(op_in), .o_ready(ready), .i_clr(clr),
        .i_op_data(op_data), .i_op_empty(op_empty), .o_op_push(op_push),
        .o_op_wdata(op_wdata), .o_op_pop(op_pop),
        .i_dt_data(dt_data), .i_dt_empty(dt_empty), .o_dt_push(dt_push),
        .o_dt_wdata(dt_wdata), .o_dt_pop(dt_pop),
        .o_al_a(al_a), .o_al_b(al_b), .o_al_op(al_op), .o_al_start(al_start),
        .i_al_done(al_done), .i_al_c(al_c), .i_al_err(al_err),
        .o_done(done), .o_result(result), .o_error(error)
    );

    always #5 clk = ~clk;

    // Stack models: combinational top, update at the edge ending the strobe cycle.
    logic [2:0]  op_mem [0:7];
    logic [31:0] dt_mem [0:7];
    logic [2:0]  op_sp = 3'd0;
    logic [2:0]  dt_sp = 3'd0;
    logic        ld = 1'b0;
    logic [2:0]  ld_op_n = 3'd0;
    logic [2:0]  ld_dt_n = 3'd0;
    logic [2:0]  ld_op [0:2];
    logic [31:0] ld_dt [0:2];

    assign op_empty = (op_sp == 3'd0);
    assign dt_empty = (dt_sp == 3'd0);
    assign op_data  = op_empty ? 3'd0 : op_mem[op_sp - 3'd1];
    assign dt_data  = dt_empty ? 32'd0 : dt_mem[dt_sp - 3'd1];

    always @(posedge clk) begin
        if (ld) begin
            for (int k = 0; k < 3; k++) begin
                op_mem[k] <= ld_op[k];
                dt_mem[k] <= ld_dt[k];
            end
            op_sp <= ld_op_n;
            dt_sp <= ld_dt_n;
        end else begin
            if (op_pop) op_sp <= op_sp - 3'd1;
            if (op_push) begin
                op_mem[op_sp] <= op_wdata;
                op_sp         <= op_sp + 3'd1;
            end
            if (dt_pop) dt_sp <= dt_sp - 3'd1;
            if (dt_push) begin
                dt_mem[dt_sp] <= dt_wdata;
                dt_sp         <= dt_sp + 3'd1;
            end
        end
    end

    // ALU model with programmable latency; keeps running across a DUT reset.
    int          alu_lat = 1;
    int          alu_cnt = 0;
    logic        alu_pend = 1'b0;
    logic [31:0] ma = 32'd0, mb = 32'd0;
    logic [2:0]  mop = 3'd0;

    always @(posedge clk) begin
        al_done <= 1'b0;
        al_err  <= 1'b0;
        if (al_start) begin
            alu_pend <= 1'b1;
            alu_cnt  <= alu_lat;
            ma       <= al_a;
            mb       <= al_b;
            mop      <= al_op;
        end else if (alu_pend) begin
            if (alu_cnt <= 1) begin
                alu_pend <= 1'b0;
                al_done  <= 1'b1;
                case (mop)
                    AD:      al_c <= ma + mb;
                    SB:      al_c <= ma - mb;
                    MU:      al_c <= ma * mb;
                    DI: begin
                        if (mb == 32'd0) begin
                            al_c   <= 32'd0;
                            al_err <= 1'b1;
                        end else begin
                            al_c <= ma / mb;
                        end
                    end
                    default: al_c <= 32'd0;
                endcase
            end else begin
                alu_cnt <= alu_cnt - 1;
            end
        end
    end

    // Strobe monitors
    int          n_start = 0, n_dtpush = 0, n_oppush = 0, n_oppop = 0, n_done = 0;
    logic [31:0] cap_a = 32'd0, cap_b = 32'd0;
    logic [2:0]  cap_op = 3'd0;

    always @(posedge clk) begin
        if (al_start) begin
            n_start <= n_start + 1;
            cap_a   <= al_a;
            cap_b   <= al_b;
            cap_op  <= al_op;
        end
        if (dt_push) n_dtpush <= n_dtpush + 1;
        if (op_push) n_oppush <= n_oppush + 1;
        if (op_pop)  n_oppop  <= n_oppop + 1;
        if (done)    n_done   <= n_done + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int b_start, b_dtpush, b_oppush, b_oppop, b_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_start  = n_start;
        b_dtpush = n_dtpush;
        b_oppush = n_oppush;
        b_oppop  = n_oppop;
        b_done   = n_done;
    endtask

    task automatic load(input logic [2:0] on, input logic [2:0] o0, input logic [2:0] o1,
                        input logic [2:0] dn, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2);
        ld_op_n  = on;
        ld_op[0] = o0;
        ld_op[1] = o1;
        ld_op[2] = 3'd0;
        ld_dt_n  = dn;
        ld_dt[0] = d0;
        ld_dt[1] = d1;
        ld_dt[2] = d2;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        snap();
    endtask

    task automatic send_op(input logic [2:0] op);
        op_valid = 1'b1;
        op_in    = op;
        @(negedge clk);
        op_valid = 1'b0;
        op_in    = 3'd0;
    endtask

    task automatic wait_ready(input string tag, input int max);
        int k = 0;
        while (!ready && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(ready), 32'd1);
    endtask

    task automatic wait_error(input string tag, input int max);
        int k = 0;
        while (!error && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(error), 32'd1);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst error", 32'(error), 32'd0);
        chk("rst strobes", {26'd0, op_push, op_pop, dt_push, dt_pop, al_start, done}, 32'd0);
        chk("rst al_a", al_a, 32'd0);
        chk("rst result", result, 32'd0);

        // NO is not accepted
        send_op(NO);
        chk("no ignored ready", 32'(ready), 32'd1);

        // Higher-precedence push: op [AD], dt [2,3], MU
        load(3'd1, AD, NO, 3'd2, 32'd2, 32'd3, 32'd0);
        send_op(MU);
        chk("hp check ready", 32'(ready), 32'd0);
        chk("hp check op_push", 32'(op_push), 32'd0);
        @(negedge clk);
        chk("hp pushop op_push", 32'(op_push), 32'd1);
        chk("hp pushop wdata", 32'(op_wdata), 32'(MU));
        @(negedge clk);
        chk("hp ready back", 32'(ready), 32'd1);
        chk("hp no al_start", 32'(n_start - b_start), 32'd0);
        chk("hp no dt_push", 32'(n_dtpush - b_dtpush), 32'd0);
        chk("hp op depth", 32'(op_sp), 32'd2);
        chk("hp op top", 32'(op_data), 32'(MU));
        chk("hp dt depth", 32'(dt_sp), 32'd2);

        // Reduce then push: op [MU], dt [4,5], SB, ALU latency 2
        alu_lat = 2;
        load(3'd1, MU, NO, 3'd2, 32'd4, 32'd5, 32'd0);
        send_op(SB);
        wait_ready("rp ready", 40);
        chk("rp one start", 32'(n_start - b_start), 32'd1);
        chk("rp al_a", cap_a, 32'd4);
        chk("rp al_b", cap_b, 32'd5);
        chk("rp al_op", 32'(cap_op), 32'(MU));
        chk("rp dt depth", 32'(dt_sp), 32'd1);
        chk("rp dt top", dt_data, 32'd20);
        chk("rp op depth", 32'(op_sp), 32'd1);
        chk("rp op top", 32'(op_data), 32'(SB));

        // Left associativity plus OK: op [AD,SB], dt [10,3,2]
        alu_lat = 1;
        load(3'd2, AD, SB, 3'd3, 32'd10, 32'd3, 32'd2);
        send_op(OK);
        wait_ready("la ready", 60);
        chk("la starts", 32'(n_start - b_start), 32'd2);
        chk("la dt pushes", 32'(n_dtpush - b_dtpush), 32'd2);
        chk("la last op", 32'(cap_op), 32'(AD));
        chk("la last a", cap_a, 32'd10);
        chk("la last b", cap_b, 32'd1);
        chk("la done count", 32'(n_done - b_done), 32'd1);
        chk("la result", result, 32'd11);
        chk("la dt empty", 32'(dt_empty), 32'd1);
        chk("la op empty", 32'(op_empty), 32'd1);
        repeat (3) @(negedge clk);
        chk("la result held", result, 32'd11);

        // Parentheses: op [LP], dt [7], RP
        load(3'd1, LP, NO, 3'd1, 32'd7, 32'd0, 32'd0);
        send_op(RP);
        wait_ready("pa ready", 10);
        chk("pa one pop", 32'(n_oppop - b_oppop), 32'd1);
        chk("pa op empty", 32'(op_empty), 32'd1);
        chk("pa no alu", 32'(n_start - b_start), 32'd0);
        chk("pa dt depth", 32'(dt_sp), 32'd1);
        chk("pa error", 32'(error), 32'd0);
        // Unmatched RP
        send_op(RP);
        wait_error("pa rp error", 10);
        send_op(MU);
        repeat (3) @(negedge clk);
        chk("pa err sticky", 32'(error), 32'd1);
        chk("pa err ready", 32'(ready), 32'd0);
        chk("pa err no push", 32'(n_oppush - b_oppush), 32'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("pa clr error", 32'(error), 32'd0);
        chk("pa clr ready", 32'(ready), 32'd1);

        // ALU fault: op [DI], dt [8,0], OK
        load(3'd1, DI, NO, 3'd2, 32'd8, 32'd0, 32'd0);
        send_op(OK);
        wait_error("af error", 30);
        repeat (2) @(negedge clk);
        chk("af no dt_push", 32'(n_dtpush - b_dtpush), 32'd0);
        chk("af no done", 32'(n_done - b_done), 32'd0);
        chk("af dt empty", 32'(dt_sp), 32'd0);
        chk("af op empty", 32'(op_sp), 32'd0);
        chk("af ready", 32'(ready), 32'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // Reset during WAIT; the late al_done must be ignored
        alu_lat = 5;
        load(3'd1, AD, NO, 3'd2, 32'd1, 32'd2, 32'd0);
        send_op(OK);
        k = 0;
        while (n_start == b_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rw started", 32'(n_start - b_start), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rw ready", 32'(ready), 32'd1);
        chk("rw strobes", {26'd0, op_push, op_pop, dt_push, dt_pop, al_start, done}, 32'd0);
        chk("rw al_a", al_a, 32'd0);
        chk("rw al_b", al_b, 32'd0);
        repeat (8) @(negedge clk);
        chk("rw late dt_push", 32'(n_dtpush - b_dtpush), 32'd0);
        chk("rw late done", 32'(n_done - b_done), 32'd0);
        chk("rw late ready", 32'(ready), 32'd1);
        chk("rw late error", 32'(error), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
